instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL expose parameter DEPTH, default 64: number of 32-bit instruction memory words.
REQ-002 SHALL expose port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL expose port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL expose port start, input, 1: one-cycle request to begin a load; sampled only in IDLE.
REQ-005 SHALL expose port num_words, input, 7: number of words to load, latched on accepted start; 0 means DEPTH.
REQ-006 SHALL expose port rx_data, input, 8: incoming program byte.
REQ-007 SHALL expose port rx_valid, input, 1: rx_data valid.
REQ-008 SHALL expose port rx_ready, output, 1: loader accepts a byte; transfer occurs when rx_valid and rx_ready are both high.
REQ-009 SHALL expose port mem_we, output, 1: instruction memory write strobe.
REQ-010 SHALL expose port mem_waddr, output, 32: byte address of the write; always word-aligned (word index * 4), matching the PC-based read addressing.
REQ-011 SHALL expose port mem_wdata, output, 32: instruction word to write.
REQ-012 SHALL expose port busy, output, 1: high from accepted start until done; the CPU is held in reset while busy.
REQ-013 SHALL expose port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL expose port err, output, 1: checksum mismatch flag, valid with done and held until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, LOAD, CHK, DONE; IDLE->LOAD on start; LOAD->CHK (CHECKSUM_EN) or LOAD->DONE after the last word's write; CHK->DONE on checksum byte accepted; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL drive rx_ready high in LOAD and CHK and low in IDLE and DONE.
REQ-017 SHALL assemble bytes little-endian: 1st accepted byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-018 SHALL assert mem_we for exactly one cycle, the cycle after the 4th byte is accepted, with mem_waddr = word_idx*4, and SHALL increment word_idx after that write.
REQ-019 SHALL keep accepting bytes during a write cycle (one byte per cycle sustained, no bubble).
REQ-020 SHALL start word_idx at 0 on every accepted start; the first write targets address 0x0, the last targets (N-1)*4.
REQ-021 SHALL drive mem_we low and hold mem_waddr and mem_wdata stable whenever no write occurs.
REQ-022 SHALL ignore start while busy, and SHALL hold partial-word state indefinitely while rx_valid is low.
REQ-023 SHALL assert done in the DONE state only and deassert busy in the same cycle.

Reset
REQ-024 SHALL on rst_n low immediately force state=IDLE, word_idx=0, byte_idx=0, rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0.
REQ-025 SHALL discard any partial word on reset mid-load; no write is issued for it.

Configuration
REQ-026 SHALL with macro LOADER_CHECKSUM_EN defined, keep a running XOR of all data bytes, accept one extra byte in CHK, and set err=1 if that byte differs from the running XOR.
REQ-027 SHALL without LOADER_CHECKSUM_EN, omit CHK and the XOR register, go LOAD->DONE directly, and tie err to 0.

Structure
REQ-028 SHALL place state encodings and the DEPTH default in a shared package/include file used by the memory and loader.
REQ-029 SHALL use one sub-module, loader_word_assembler, for byte-lane packing and the 4-byte count; the FSM stays in the top.

Verification
REQ-030 SHALL cover: num_words=1, bytes 0x13,0x05,0x50,0x00 back-to-back -> one mem_we at addr 0x0, wdata 0x00500513, done the cycle after the write.
REQ-031 SHALL cover: num_words=2, 8 back-to-back bytes -> writes at 0x0 and 0x4, exactly 2 mem_we pulses, no rx_ready drop between words.
REQ-032 SHALL cover: rx_valid toggling 1,0,0,1 between bytes -> same wdata as the gap-free case, write delayed only by the gaps.
REQ-033 SHALL cover: num_words=0 -> 64 writes, last at 0xFC, then done.
REQ-034 SHALL cover: rst_n low after 2 bytes of word 0 -> all outputs 0 immediately, no mem_we; a new start loads correctly from 0x0.
REQ-035 SHALL cover (LOADER_CHECKSUM_EN): bytes 0x13,0x05,0x50,0x00 with checksum 0x46 -> err=0; with checksum 0x47 -> err=1 at done.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding,
// default memory depth and word-index width.
package instr_mem_loader_pkg;

    localparam int LDR_DEPTH = 64;
    localparam int IDX_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } ldr_state_e;

    // Byte address of a word, matching the PC-based fetch addressing.
    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
        return 32'(idx) << 2;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface instr_mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Little-endian byte packer: collects three low bytes and presents the full
// word combinationally together with the 4th byte (word_fire).
module loader_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_fire,
    output logic [31:0] word
);
    logic [1:0]  byte_idx;
    logic [23:0] lo;

    assign word_fire = byte_en && (byte_idx == 2'd3);
    assign word      = {byte_in, lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            lo       <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            lo       <= 24'd0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lo[7:0]   <= byte_in;
                2'd1:    lo[15:8]  <= byte_in;
                2'd2:    lo[23:16] <= byte_in;
                default: lo        <= lo;
            endcase
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time program loader: streams bytes into 32-bit instruction words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH = LDR_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W-1:0]   num_words,
    instr_mem_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    ldr_state_e       state, state_nxt;
    logic [IDX_W-1:0] n_words, word_idx;
    logic             start_acc, byte_xfer, data_xfer, word_fire, last_written;
    logic [31:0]      word;

    assign start_acc    = (state == ST_IDLE) && start;
    assign byte_xfer    = bus.rx_valid && bus.rx_ready;
    assign data_xfer    = byte_xfer && (state == ST_LOAD);
    assign last_written = bus.mem_we && (word_idx == n_words);

    loader_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_acc),
        .byte_en   (data_xfer),
        .byte_in   (bus.rx_data),
        .word_fire (word_fire),
        .word      (word)
    );

    always_comb begin
        state_nxt    = state;
        bus.rx_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                busy = 1'b1;
                // Stream stalls for the final write cycle so no byte past the
                // program is swallowed as data.
                bus.rx_ready = (word_idx != n_words);
                if (last_written) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                busy         = 1'b1;
                bus.rx_ready = 1'b1;
                if (bus.rx_valid) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            n_words       <= '0;
            word_idx      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= 32'd0;
            bus.mem_wdata <= 32'd0;
        end else begin
            state      <= state_nxt;
            bus.mem_we <= word_fire;
            if (start_acc) begin
                n_words  <= (num_words == '0) ? IDX_W'(DEPTH) : num_words;
                word_idx <= '0;
            end else if (word_fire) begin
                word_idx      <= word_idx + IDX_W'(1);
                bus.mem_waddr <= word_addr(word_idx);
                bus.mem_wdata <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else if (start_acc) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else begin
            if (data_xfer) csum <= csum ^ bus.rx_data;
            if (byte_xfer && state == ST_CHK) err <= (bus.rx_data != csum);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: byte-count based reference model,
// per-cycle output compare, directed and randomized loads.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [6:0] num_words = 7'd0;
    logic       busy, done, err;

    instr_mem_loader_if bus();

    instr_mem_loader #(.DEPTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks bytes taken per load and derives every output
    // from byte counts and the cycle of the last data / checksum byte.
    logic        exp_rx_ready = 0, exp_we = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
    logic [31:0] exp_waddr = 0, exp_wdata = 0;
    bit          m_active = 0, m_chk_got = 0;
    int          m_n = 0, m_taken = 0, t_last = 0, t_done = -1;
    logic [7:0]  m_xor = 0;
    logic [7:0]  wb [4];

    initial forever begin
        bit         xfer, prev_done;
        logic [7:0] xin;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_taken = 0; m_n = 0; m_chk_got = 0; t_done = -1;
            exp_rx_ready = 0; exp_we = 0; exp_waddr = 0; exp_wdata = 0;
            exp_busy = 0; exp_done = 0; exp_err = 0;
        end else begin
            xfer      = bus.rx_valid && exp_rx_ready;
            xin       = bus.rx_data;
            prev_done = exp_done;
            cyc++;
            exp_we   = 0;
            exp_done = 0;
            if (m_active) begin
                if (xfer) begin
                    if (m_taken < 4 * m_n) begin
                        wb[m_taken % 4] = xin;
                        m_xor = m_xor ^ xin;
                        m_taken++;
                        if (m_taken % 4 == 0) begin
                            exp_we    = 1;
                            exp_waddr = 32'((m_taken / 4 - 1) * 4);
                            exp_wdata = {wb[3], wb[2], wb[1], wb[0]};
                        end
                        if (m_taken == 4 * m_n) t_last = cyc - 1;
                    end else begin
                        m_chk_got = 1;
                        exp_err   = (xin != m_xor);
                        t_done    = cyc;
                    end
                end
                if (!CHK && m_taken == 4 * m_n && cyc == t_last + 2) t_done = cyc;
                if (cyc == t_done) begin
                    exp_done = 1;
                    m_active = 0;
                end
            end else if (start && !prev_done) begin
                m_active  = 1;
                m_n       = (num_words == 0) ? 64 : int'(num_words);
                m_taken   = 0;
                m_xor     = 0;
                m_chk_got = 0;
                t_done    = -1;
                t_last    = 1 << 30;
                exp_err   = 0;
            end
            exp_busy     = m_active;
            exp_rx_ready = m_active && (m_taken < 4 * m_n ||
                                        (CHK && !m_chk_got && cyc >= t_last + 2));
        end
    end

    // Compare process plus write/done capture.
    int          wr_cnt = 0, done_seen = 0, last_wr_cyc = 0, done_cyc = 0;
    logic        err_at_done = 0;
    logic [31:0] wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];

    initial forever begin
        @(negedge clk);
        check("rx_ready",  bus.rx_ready,  exp_rx_ready);
        check("mem_we",    bus.mem_we,    exp_we);
        check("mem_waddr", bus.mem_waddr, exp_waddr);
        check("mem_wdata", bus.mem_wdata, exp_wdata);
        check("busy",      busy,          exp_busy);
        check("done",      done,          exp_done);
        check("err",       err,           exp_err);
        if (bus.mem_we === 1'b1) begin
            if (wr_cnt < 1024) begin
                wr_addr_log[wr_cnt] = bus.mem_waddr;
                wr_data_log[wr_cnt] = bus.mem_wdata;
            end
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_seen++;
            done_cyc    = cyc;
            err_at_done = err;
        end
    end

    logic [7:0] pbytes [0:255];
    int         gaps   [0:255];

    task automatic pulse_start(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int k;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        k  = 0;
        ok = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk); #1;
            k++;
        end
        bus.rx_valid = 1'b0;
        if (!ok) check("rx_ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic load(input logic [6:0] n, input bit bad, input bit poke_start, output int start_c);
        int         neff, d0, k;
        logic [7:0] x;
        neff    = (n == 0) ? 64 : int'(n);
        d0      = done_seen;
        start_c = cyc;
        pulse_start(n);
        x = 8'd0;
        for (int i = 0; i < 4 * neff; i++) begin
            send_byte(pbytes[i], gaps[i]);
            x = x ^ pbytes[i];
            if (poke_start && i == 1) pulse_start(7'd3);
        end
        if (CHK) send_byte(bad ? (x ^ 8'h01) : x, 0);
        k = 0;
        while (done_seen == d0 && k < 300) begin @(posedge clk); #1; k++; end
        check("done_timeout", 32'(done_seen - d0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_prog_13055000();
        pbytes[0] = 8'h13; pbytes[1] = 8'h05; pbytes[2] = 8'h50; pbytes[3] = 8'h00;
    endtask

    initial begin
        int sc, lat0, lat1, w0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) gaps[i] = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy",   busy,          32'd0);
        check("rst_ready",  bus.rx_ready,  32'd0);
        check("rst_waddr",  bus.mem_waddr, 32'd0);
        check("rst_wdata",  bus.mem_wdata, 32'd0);
        @(posedge clk); #1;

        // Single word, gap-free.
        set_prog_13055000();
        w0 = wr_cnt;
        load(7'd1, 1'b0, 1'b0, sc);
        check("w1_count", 32'(wr_cnt - w0), 32'd1);
        check("w1_addr",  wr_addr_log[w0], 32'h0);
        check("w1_data",  wr_data_log[w0], 32'h00500513);
        check("w1_done_after_write", 32'(done_cyc - last_wr_cyc), CHK ? 32'd2 : 32'd1);
        check("w1_err",   err_at_done, 32'd0);
        lat0 = last_wr_cyc - sc;

        // Same word with a wrong checksum (err only exists with the checksum build).
        w0 = wr_cnt;
        load(7'd1, 1'b1, 1'b0, sc);
        check("bad_data", wr_data_log[w0], 32'h00500513);
        check("bad_err",  err_at_done, CHK ? 32'd1 : 32'd0);
        check("err_hold", err,         CHK ? 32'd1 : 32'd0);

        // Two words back-to-back.
        for (int i = 0; i < 8; i++) pbytes[i] = 8'($urandom);
        w0 = wr_cnt;
        load(7'd2, 1'b0, 1'b0, sc);
        check("w2_count", 32'(wr_cnt - w0), 32'd2);
        check("w2_addr0", wr_addr_log[w0],     32'h0);
        check("w2_addr1", wr_addr_log[w0 + 1], 32'h4);
        check("w2_data1", wr_data_log[w0 + 1], {pbytes[7], pbytes[6], pbytes[5], pbytes[4]});

        // rx_valid gaps: 1,0,0,1 pattern between bytes.
        set_prog_13055000();
        gaps[1] = 2; gaps[2] = 2; gaps[3] = 2;
        w0 = wr_cnt;
        load(7'd1, 1'b0, 1'b0, sc);
        for (int i = 0; i < 4; i++) gaps[i] = 0;
        lat1 = last_wr_cyc - sc;
        check("gap_data",  wr_data_log[w0], 32'h00500513);
        check("gap_delay", 32'(lat1 - lat0), 32'd6);

        // num_words = 0 loads the full depth.
        for (int i = 0; i < 256; i++) pbytes[i] = 8'($urandom);
        w0 = wr_cnt;
        load(7'd0, 1'b0, 1'b0, sc);
        check("full_count", 32'(wr_cnt - w0), 32'd64);
        check("full_last_addr", wr_addr_log[w0 + 63], 32'hFC);
        check("full_last_data", wr_data_log[w0 + 63],
              {pbytes[255], pbytes[254], pbytes[253], pbytes[252]});

        // Reset after two bytes of word 0.
        set_prog_13055000();
        w0 = wr_cnt;
        pulse_start(7'd1);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy,          32'd0);
        check("mid_rst_ready", bus.rx_ready,  32'd0);
        check("mid_rst_we",    bus.mem_we,    32'd0);
        check("mid_rst_waddr", bus.mem_waddr, 32'd0);
        check("mid_rst_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_write", 32'(wr_cnt - w0), 32'd0);
        load(7'd1, 1'b0, 1'b0, sc);
        check("after_rst_addr", wr_addr_log[w0], 32'h0);
        check("after_rst_data", wr_data_log[w0], 32'h00500513);

        // Randomized loads, random gaps, stray start pulses, random checksum errors.
        for (int it = 0; it < 20; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < 4 * n; i++) begin
                pbytes[i] = 8'($urandom);
                gaps[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            load(7'(n), 1'($urandom_range(0, 1)), 1'(it % 3 == 0), sc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
